// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply (shift-add) / divide (restoring), 32 iterations each.
// Optional MULTDIV_EARLY_DIV0_EN: divide by zero completes right after capture.
module mult_div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nxt;
  logic [31:0] op_a, op_b, mag_a, mag_b, div_res;
  logic [63:0] acc, acc_nxt, term;
  logic [32:0] diff;
  logic [5:0]  cnt;
  logic        start, fin, mul_exc, div_exc;
  assign start = ctrl_MULT | ctrl_DIV;
  assign busy  = state == MUL || state == DIV;
  assign mag_a = data_operandA[31] ? -data_operandA : data_operandA;
  assign mag_b = op_b[31] ? -op_b : op_b;
  assign term  = {{32{op_a[31]}}, op_a} << cnt[4:0];
  // acc doubles as {remainder, dividend/quotient} during a divide
  assign diff  = {1'b0, acc[62:31]} - {1'b0, mag_b};
  always_comb begin
    acc_nxt = state == MUL ? (op_b[cnt[4:0]] ? (cnt == 6'd31 ? acc - term : acc + term) : acc)
                           : (diff[32] ? {acc[62:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1});
`ifdef MULTDIV_EARLY_DIV0_EN
    fin = busy && (cnt == 6'd32 || (state == DIV && op_b == 32'd0));
`else
    fin = busy && cnt == 6'd32;
`endif
    mul_exc = !(&acc[63:31] || !(|acc[63:31]));
    div_exc = op_b == 32'd0 || (op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF);
    div_res = op_b == 32'd0 ? 32'd0 : (op_a[31] ^ op_b[31]) ? -acc[31:0] : acc[31:0];
    state_nxt = start ? (ctrl_MULT ? MUL : DIV) : fin ? DONE : state == DONE ? IDLE : state;
  end
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clock) begin
    if (reset) begin
      op_a <= '0;
      op_b <= '0;
      acc <= '0;
      cnt <= '0;
      data_result <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= fin && !start;
      if (start) begin
        op_a <= data_operandA;
        op_b <= data_operandB;
        cnt <= '0;
        acc <= ctrl_MULT ? 64'd0 : {32'd0, mag_a};
      end else if (fin) begin
        data_result <= state == MUL ? acc[31:0] : div_res;
        data_exception <= state == MUL ? mul_exc : div_exc;
      end else if (busy) begin
        acc <= acc_nxt;
        cnt <= cnt + 6'd1;
      end
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed checks against an arithmetic reference model.
module tb_mult_div_unit;
  logic        clock, reset, ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB, data_result;
  logic        data_exception, data_resultRDY, busy;
  int vecs = 0, errs = 0;

  mult_div_unit dut (
    .clock(clock), .reset(reset),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errs=%0d", errs);
    $fatal(1, "watchdog");
  end

  function automatic logic [32:0] model(input bit mul, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int sa, sb;
    logic [63:0] pv;
    sa = a;
    sb = b;
    if (mul) begin
      p = longint'(sa) * longint'(sb);
      pv = p;
      return {!(p >= -64'sd2147483648 && p <= 64'sd2147483647), pv[31:0]};
    end
    if (b == 0) return {1'b1, 32'd0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    return {1'b0, 32'(sa / sb)};
  endfunction

  function automatic int exp_lat(input bit mul, input logic [31:0] b);
`ifdef MULTDIV_EARLY_DIV0_EN
    return (!mul && b == 0) ? 1 : 33;
`else
    return 33;
`endif
  endfunction

  function automatic logic [31:0] rnd_val();
    logic [31:0] sp [4] = '{32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1};
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 200)) - 32'd100;
      2: return sp[$urandom_range(0, 3)];
      default: return 32'($urandom_range(0, 70000));
    endcase
  endfunction

  // caller is at a negedge; returns at the negedge following the capture edge
  task automatic start_op(input bit mul, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT = mul;
    ctrl_DIV = !mul;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_rdy(output int lat, output logic [31:0] res, output logic exc, output logic bsy);
    lat = 0;
    while (data_resultRDY !== 1'b1 && lat < 60) begin
      @(negedge clock);
      lat++;
    end
    res = data_result;
    exc = data_exception;
    bsy = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ctrl_MULT = 1'b1;
    ctrl_DIV = 1'b0;
    data_operandA = 32'd3;
    data_operandB = 32'd4;
    repeat (2) @(negedge clock);
    vecs++; if (data_result !== 32'd0) begin errs++; $display("FAIL reset_result: got %h want 0", data_result); end
    vecs++; if (data_exception !== 1'b0) begin errs++; $display("FAIL reset_exc: got %b want 0", data_exception); end
    vecs++; if (data_resultRDY !== 1'b0) begin errs++; $display("FAIL reset_rdy: got %b want 0", data_resultRDY); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_priority_busy: got %b want 0", busy); end
    reset = 1'b0;
    ctrl_MULT = 1'b0;
    @(negedge clock);
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_directed();
    bit          dm [6] = '{1, 1, 1, 0, 0, 0};
    logic [31:0] da [6] = '{32'd7, 32'h0001_0000, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 32'h8000_0000, 32'd5};
    logic [31:0] db [6] = '{32'hFFFF_FFFA, 32'h0001_0000, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] dr [6] = '{32'hFFFF_FFD6, 32'd0, 32'd1, 32'hFFFF_FFF2, 32'h8000_0000, 32'd0};
    bit          de [6] = '{0, 1, 0, 0, 1, 1};
    int lat;
    logic [31:0] res;
    logic exc, bsy;
    for (int i = 0; i < 6; i++) begin
      start_op(dm[i], da[i], db[i]);
      vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL dir%0d_busy: got %b want 1", i, busy); end
      wait_rdy(lat, res, exc, bsy);
      vecs++; if (lat != exp_lat(dm[i], db[i])) begin errs++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, exp_lat(dm[i], db[i])); end
      vecs++; if (res !== dr[i]) begin errs++; $display("FAIL dir%0d_result: got %h want %h", i, res, dr[i]); end
      vecs++; if (exc !== de[i]) begin errs++; $display("FAIL dir%0d_exc: got %b want %b", i, exc, de[i]); end
      vecs++; if (bsy !== 1'b0) begin errs++; $display("FAIL dir%0d_busy_done: got %b want 0", i, bsy); end
      @(negedge clock);
      vecs++; if (data_resultRDY !== 1'b0) begin errs++; $display("FAIL dir%0d_rdy_single: got %b want 0", i, data_resultRDY); end
    end
    repeat (5) @(negedge clock);
    vecs++; if (data_result !== 32'd0 || data_exception !== 1'b1) begin errs++; $display("FAIL idle_hold: got %h/%b want 00000000/1", data_result, data_exception); end
  endtask

  task automatic test_random(input bit mul, input int n);
    int lat;
    logic [31:0] a, b, res;
    logic exc, bsy;
    logic [32:0] m;
    for (int i = 0; i < n; i++) begin
      a = rnd_val();
      b = rnd_val();
      m = model(mul, a, b);
      start_op(mul, a, b);
      wait_rdy(lat, res, exc, bsy);
      vecs++; if (lat != exp_lat(mul, b)) begin errs++; $display("FAIL rnd_lat %s %h %h: got %0d want %0d", mul ? "mul" : "div", a, b, lat, exp_lat(mul, b)); end
      vecs++; if (res !== m[31:0] || exc !== m[32]) begin errs++; $display("FAIL rnd_%s %h %h: got %h/%b want %h/%b", mul ? "mul" : "div", a, b, res, exc, m[31:0], m[32]); end
      @(negedge clock);
    end
  endtask

  task automatic test_restart();
    int lat, rdys = 0;
    logic [31:0] res;
    logic exc, bsy;
    start_op(1'b1, $urandom, $urandom);
    repeat (9) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) rdys++;
    end
    start_op(1'b0, 32'd9, 32'd3);
    wait_rdy(lat, res, exc, bsy);
    vecs++; if (rdys != 0) begin errs++; $display("FAIL restart_early_rdy: got %0d pulses want 0", rdys); end
    vecs++; if (lat != 33) begin errs++; $display("FAIL restart_latency: got %0d want 33", lat); end
    vecs++; if (res !== 32'd3 || exc !== 1'b0) begin errs++; $display("FAIL restart_result: got %h/%b want 00000003/0", res, exc); end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] res;
    logic exc, bsy;
    logic [32:0] m;
    start_op(1'b1, 32'd1234, 32'hFFFF_FF00);
    wait_rdy(lat, res, exc, bsy);
    m = model(1'b0, 32'hFFFF_F000, 32'd3);
    start_op(1'b0, 32'hFFFF_F000, 32'd3);
    vecs++; if (data_resultRDY !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL b2b_restart: got rdy=%b busy=%b want 0/1", data_resultRDY, busy); end
    wait_rdy(lat, res, exc, bsy);
    vecs++; if (lat != 33) begin errs++; $display("FAIL b2b_latency: got %0d want 33", lat); end
    vecs++; if (res !== m[31:0] || exc !== m[32]) begin errs++; $display("FAIL b2b_result: got %h/%b want %h/%b", res, exc, m[31:0], m[32]); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int lat, rdys = 0;
    logic [31:0] res;
    logic exc, bsy;
    start_op(1'b1, 32'h0001_0001, 32'h0001_0000);
    wait_rdy(lat, res, exc, bsy);
    vecs++; if (res !== 32'h0001_0000 || exc !== 1'b1) begin errs++; $display("FAIL pre_reset_mul: got %h/%b want 00010000/1", res, exc); end
    @(negedge clock);
    start_op(1'b0, 32'd1000, 32'd7);
    repeat (19) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    vecs++; if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL mid_reset: got %h/%b/%b/%b want 0/0/0/0", data_result, data_exception, data_resultRDY, busy);
    end
    reset = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) rdys++;
    end
    vecs++; if (rdys != 0) begin errs++; $display("FAIL mid_reset_no_rdy: got %0d pulses want 0", rdys); end
  endtask

  initial begin
    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    @(negedge clock);
    test_reset();
    test_directed();
    test_random(1'b1, 40);
    test_random(1'b0, 40);
    test_restart();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-003 SHALL have port: data_operandA  input  32  signed two's-complement multiplicand / dividend.
REQ-004 SHALL have port: data_operandB  input  32  signed two's-complement multiplier / divisor.
REQ-005 SHALL have port: ctrl_MULT  input  1  one-cycle start pulse for multiply.
REQ-006 SHALL have port: ctrl_DIV  input  1  one-cycle start pulse for divide.
REQ-007 SHALL have port: data_result  output  32  product low word or quotient, held until next completion.
REQ-008 SHALL have port: data_exception  output  1  overflow / divide fault, valid with data_resultRDY.
REQ-009 SHALL have port: data_resultRDY  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: busy  output  1  high while an operation is in flight.

Function
REQ-011 SHALL implement FSM states: IDLE, MUL, DIV, DONE.
REQ-012 Operand capture: on a rising edge with ctrl_MULT or ctrl_DIV high, SHALL latch both operands, clear the iteration counter and enter MUL or DIV; operand inputs are don't-care afterwards.
REQ-013 Start priority: ctrl_MULT and ctrl_DIV both high SHALL start a multiply.
REQ-014 Restart: a start pulse in MUL, DIV or DONE SHALL abort the current operation with no RDY pulse and restart with the new operands.
REQ-015 Multiply: signed radix-2 shift-add, one iteration per clock, 32 iterations, 64-bit partial product.
REQ-016 Divide: restoring division on operand magnitudes, 32 iterations, one per clock; quotient sign = signA XOR signB; truncation toward zero.
REQ-017 Latency: start sampled at edge t SHALL give data_resultRDY high for exactly the one cycle after edge t+33; data_result and data_exception update at that same edge.
REQ-018 After DONE, FSM SHALL return to IDLE on the next edge; data_resultRDY SHALL never be high two cycles in a row.
REQ-019 Multiply result SHALL be product[31:0]; data_exception=1 iff product[63:31] is not all-zeros or all-ones.
REQ-020 Divide by zero SHALL give data_result=0 and data_exception=1.
REQ-021 Divide 0x80000000 / 0xFFFFFFFF SHALL give data_result=0x80000000 and data_exception=1.
REQ-022 All other divides SHALL give data_exception=0.
REQ-023 busy SHALL be high in MUL and DIV and low in IDLE and DONE.
REQ-024 data_result and data_exception SHALL hold their last values in IDLE.

Reset
REQ-025 reset high at an edge SHALL force IDLE and set data_result=0, data_exception=0, data_resultRDY=0, busy=0, counter=0; this applies mid-operation, and no RDY pulse follows.
REQ-026 reset SHALL take priority over a simultaneous ctrl_MULT or ctrl_DIV.

Configuration
REQ-027 Macro MULTDIV_EARLY_DIV0_EN, when defined: a divide with data_operandB=0 SHALL skip iteration and pulse data_resultRDY in the cycle after edge t+1, with the REQ-020 values.
REQ-028 Without MULTDIV_EARLY_DIV0_EN, divide-by-zero SHALL follow the full 33-cycle latency of REQ-017.

Verification
REQ-029 MULT A=7, B=-6 -> RDY at t+33, result=0xFFFFFFD6, exception=0.
REQ-030 MULT A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1; MULT A=-1, B=-1 -> result=1, exception=0.
REQ-031 DIV A=-100, B=7 -> result=0xFFFFFFF2 (-14), exception=0; DIV A=0x80000000, B=-1 -> result=0x80000000, exception=1.
REQ-032 DIV A=5, B=0 -> result=0, exception=1; RDY at t+33 without the macro, at t+1 with it.
REQ-033 MULT started, DIV A=9, B=3 pulsed at t+10 -> no RDY for the multiply, RDY at t+43, result=3.
REQ-034 reset asserted at t+20 of a DIV -> all outputs 0 at the next edge, no RDY within the next 40 cycles.
